// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: memory commands, FSM states, owner ids.
package mem_port_arbiter_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_ACK   = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Only MREAD and MWRITE are real requests; 00 and 10 are ignored.
    function automatic logic is_access(input logic [CMD_W-1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester channel into the RAM port arbiter (CPU path or DMA engine).
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 16
);
    logic             req;
    logic [CMD_W-1:0] cmd;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic             ack;
    logic [DW-1:0]    rdata;

    modport master (output req, cmd, addr, wdata, input ack, rdata);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way picker: fixed CPU priority or alternate away from the last winner.
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic   valid0,
    input  logic   valid1,
    input  owner_e last,
    input  logic   prio_mode,
    output owner_e grant
);

    always_comb begin
        grant = OWN_CPU;
        if (valid0 && valid1) begin
            grant = (prio_mode || (last == OWN_DMA)) ? OWN_CPU : OWN_DMA;
        end else if (valid1) begin
            grant = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between the CPU path and the DMA requester;
// each grant becomes exactly one memory access followed by a one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 16,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned CPU_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave cpu,
    mem_port_arbiter_if.slave dma,
    output logic [CMD_W-1:0] mem_cmd,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    write_data,
    input  logic [DW-1:0]    read_data
);

    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    arb_state_e    state;
    owner_e        owner;
    owner_e        last;
    owner_e        grant;
    logic [CW-1:0] cnt;
    logic          cpu_valid;
    logic          dma_valid;

    assign cpu_valid = cpu.req && is_access(cpu.cmd);
    assign dma_valid = dma.req && is_access(dma.cmd);

    mem_port_arbiter_rr_pick2 u_pick (
        .valid0    (cpu_valid),
        .valid1    (dma_valid),
        .last      (last),
        .prio_mode (1'(CPU_PRIO)),
        .grant     (grant)
    );

    // mem_cmd/mem_addr/write_data double as the latched access for the whole ISSUE phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_CPU;
            last       <= OWN_DMA;
            cnt        <= '0;
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            write_data <= '0;
            cpu.ack    <= 1'b0;
            dma.ack    <= 1'b0;
            cpu.rdata  <= '0;
            dma.rdata  <= '0;
        end else begin
            cpu.ack <= 1'b0;
            dma.ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    mem_cmd <= MNONE;
                    if (cpu_valid || dma_valid) begin
                        owner <= grant;
                        cnt   <= CW'(READ_LAT - 1);
                        state <= ARB_ISSUE;
                        if (grant == OWN_DMA) begin
                            mem_cmd    <= dma.cmd;
                            mem_addr   <= dma.addr;
                            write_data <= dma.wdata;
                        end else begin
                            mem_cmd    <= cpu.cmd;
                            mem_addr   <= cpu.addr;
                            write_data <= cpu.wdata;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if ((mem_cmd == MWRITE) || (cnt == '0)) begin
                        if (mem_cmd == MREAD) begin
                            if (owner == OWN_DMA) dma.rdata <= read_data;
                            else                  cpu.rdata <= read_data;
                        end
                        mem_cmd <= MNONE;
                        state   <= ARB_ACK;
                        if (owner == OWN_DMA) dma.ack <= 1'b1;
                        else                  cpu.ack <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ARB_ACK: begin
                    mem_cmd <= MNONE;
                    last    <= owner;
                    state   <= ARB_IDLE;
                end
                default: begin
                    mem_cmd <= MNONE;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin/READ_LAT=2 instance with an ack scoreboard,
// plus a CPU-priority/READ_LAT=1 instance.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned AW     = 9;
    localparam int unsigned DW     = 16;
    localparam int unsigned RR_LAT = 2;
    localparam int unsigned FP_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_rr, rst_fp;
    int   n_assert = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) rr_cpu ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) rr_dma ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) fp_cpu ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) fp_dma ();

    logic [1:0]    rr_mem_cmd, fp_mem_cmd;
    logic [AW-1:0] rr_mem_addr, fp_mem_addr;
    logic [DW-1:0] rr_wd, fp_wd, rr_rd, fp_rd;

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LAT(RR_LAT), .CPU_PRIO(0)) u_rr (
        .clk(clk), .reset(rst_rr), .cpu(rr_cpu), .dma(rr_dma),
        .mem_cmd(rr_mem_cmd), .mem_addr(rr_mem_addr), .write_data(rr_wd), .read_data(rr_rd)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .READ_LAT(FP_LAT), .CPU_PRIO(1)) u_fp (
        .clk(clk), .reset(rst_fp), .cpu(fp_cpu), .dma(fp_dma),
        .mem_cmd(fp_mem_cmd), .mem_addr(fp_mem_addr), .write_data(fp_wd), .read_data(fp_rd)
    );

    // RAM models: data is only valid in the READ_LAT-th consecutive MREAD cycle.
    logic [DW-1:0] rr_ram [0:(1<<AW)-1];
    logic [DW-1:0] fp_ram [0:(1<<AW)-1];
    int rr_rdcnt = 0;
    int fp_rdcnt = 0;

    always @(posedge clk) begin
        if (rr_mem_cmd == MWRITE) rr_ram[rr_mem_addr] <= rr_wd;
        rr_rdcnt <= (rr_mem_cmd == MREAD) ? rr_rdcnt + 1 : 0;
        if (fp_mem_cmd == MWRITE) fp_ram[fp_mem_addr] <= fp_wd;
        fp_rdcnt <= (fp_mem_cmd == MREAD) ? fp_rdcnt + 1 : 0;
    end

    assign rr_rd = (rr_mem_cmd == MREAD && rr_rdcnt == int'(RR_LAT) - 1) ? rr_ram[rr_mem_addr] : 16'hDEAD;
    assign fp_rd = (fp_mem_cmd == MREAD && fp_rdcnt == int'(FP_LAT) - 1) ? fp_ram[fp_mem_addr] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic          dma;
        logic [DW-1:0] cpu_rd;
        logic [DW-1:0] dma_rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   rr_cpu_acks = 0;
    int   rr_dma_acks = 0;

    // Scoreboard: every ack on the round-robin instance pops one expected completion.
    always @(negedge clk) begin
        if (rr_cpu.ack === 1'b1 || rr_dma.ack === 1'b1) begin
            chk("ack_mutex", 32'(rr_cpu.ack & rr_dma.ack), 0);
            chk("cmd_none_in_ack", 32'(rr_mem_cmd), 32'(MNONE));
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_owner", 32'(rr_dma.ack), 32'(mon_e.dma));
                chk("sb_cpu_rdata", 32'(rr_cpu.rdata), 32'(mon_e.cpu_rd));
                chk("sb_dma_rdata", 32'(rr_dma.rdata), 32'(mon_e.dma_rd));
            end
            if (rr_cpu.ack === 1'b1) rr_cpu_acks++;
            if (rr_dma.ack === 1'b1) rr_dma_acks++;
        end
    end

    task automatic rr_access(input string tag, input logic who, input logic [1:0] cmd,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input int exp_cyc, input int exp_iss,
                             input logic [DW-1:0] exp_cpu, input logic [DW-1:0] exp_dma,
                             input bit drop_early);
        exp_t e;
        int   cyc;
        int   iss;
        bit   seen;
        e.dma = who; e.cpu_rd = exp_cpu; e.dma_rd = exp_dma;
        sb.push_back(e);
        if (who) begin
            rr_dma.req = 1'b1; rr_dma.cmd = cmd; rr_dma.addr = addr; rr_dma.wdata = wd;
        end else begin
            rr_cpu.req = 1'b1; rr_cpu.cmd = cmd; rr_cpu.addr = addr; rr_cpu.wdata = wd;
        end
        cyc = 1; iss = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rr_mem_cmd == cmd) begin
                if (iss == 0) begin
                    chk({tag, "_addr"}, 32'(rr_mem_addr), 32'(addr));
                    if (cmd == MWRITE) chk({tag, "_wdata"}, 32'(rr_wd), 32'(wd));
                end
                iss++;
            end
            if (drop_early && cyc == 2) begin
                rr_cpu.req = 1'b0; rr_cpu.cmd = 2'b00; rr_cpu.addr = ~addr; rr_cpu.wdata = ~wd;
            end
            seen = (rr_cpu.ack === 1'b1) || (rr_dma.ack === 1'b1);
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_issue_cycles"}, 32'(iss), 32'(exp_iss));
        rr_cpu.req = 1'b0; rr_dma.req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int bad;
        int n;
        int cyc;
        {rr_cpu.req, rr_cpu.cmd, rr_cpu.addr, rr_cpu.wdata} = '0;
        {rr_dma.req, rr_dma.cmd, rr_dma.addr, rr_dma.wdata} = '0;
        {fp_cpu.req, fp_cpu.cmd, fp_cpu.addr, fp_cpu.wdata} = '0;
        {fp_dma.req, fp_dma.cmd, fp_dma.addr, fp_dma.wdata} = '0;
        rst_rr = 1'b1;
        rst_fp = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_mem_cmd", 32'(rr_mem_cmd), 32'(MNONE));
        chk("rst_mem_addr", 32'(rr_mem_addr), 0);
        chk("rst_write_data", 32'(rr_wd), 0);
        chk("rst_acks", 32'({rr_cpu.ack, rr_dma.ack}), 0);
        chk("rst_rdata", 32'({rr_cpu.rdata, rr_dma.rdata}), 0);
        chk("rst_fp_mem_cmd", 32'(fp_mem_cmd), 32'(MNONE));
        rst_rr = 1'b0;
        rst_fp = 1'b0;
        @(negedge clk);

        rr_access("cpu_wr", 1'b0, MWRITE, 9'h005, 16'h1234, 3, 1, 16'h0000, 16'h0000, 1'b0);
        rr_access("dma_rd", 1'b1, MREAD, 9'h005, 16'h0000, 2 + RR_LAT, RR_LAT, 16'h0000, 16'h1234, 1'b0);
        rr_access("cpu_rd", 1'b0, MREAD, 9'h005, 16'h0000, 2 + RR_LAT, RR_LAT, 16'h1234, 16'h1234, 1'b0);

        // Request withdrawn right after the grant still completes with one ack.
        base = rr_cpu_acks;
        rr_access("cpu_wr_drop", 1'b0, MWRITE, 9'h010, 16'hBEEF, 3, 1, 16'h1234, 16'h1234, 1'b1);
        repeat (4) @(negedge clk);
        chk("drop_single_ack", 32'(rr_cpu_acks - base), 1);
        rr_access("dma_rd_beef", 1'b1, MREAD, 9'h010, 16'h0000, 2 + RR_LAT, RR_LAT, 16'h1234, 16'hBEEF, 1'b0);

        // Non-request command encodings are never granted.
        base = rr_cpu_acks + rr_dma_acks;
        bad = 0;
        rr_cpu.req = 1'b1; rr_cpu.cmd = 2'b10; rr_cpu.addr = 9'h007;
        repeat (8) begin
            @(negedge clk);
            if (rr_mem_cmd != MNONE) bad++;
        end
        rr_cpu.cmd = 2'b00;
        repeat (8) begin
            @(negedge clk);
            if (rr_mem_cmd != MNONE) bad++;
        end
        rr_cpu.req = 1'b0;
        chk("bad_cmd_no_issue", 32'(bad), 0);
        chk("bad_cmd_no_ack", 32'(rr_cpu_acks + rr_dma_acks - base), 0);

        // Reset while a read is in ISSUE.
        rr_cpu.req = 1'b1; rr_cpu.cmd = MREAD; rr_cpu.addr = 9'h005;
        @(negedge clk);
        chk("rst_mid_pre_issue", 32'(rr_mem_cmd), 32'(MREAD));
        rst_rr = 1'b1;
        rr_cpu.req = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_cmd", 32'(rr_mem_cmd), 32'(MNONE));
        chk("rst_mid_acks", 32'({rr_cpu.ack, rr_dma.ack}), 0);
        chk("rst_mid_cpu_rdata", 32'(rr_cpu.rdata), 0);
        chk("rst_mid_dma_rdata", 32'(rr_dma.rdata), 0);

        // Both requesters held from reset: CPU, DMA, CPU, DMA, one ack every 3 cycles.
        rr_cpu.req = 1'b1; rr_cpu.cmd = MWRITE; rr_cpu.addr = 9'h020; rr_cpu.wdata = 16'hAAAA;
        rr_dma.req = 1'b1; rr_dma.cmd = MWRITE; rr_dma.addr = 9'h021; rr_dma.wdata = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.dma = 1'(i % 2); e.cpu_rd = '0; e.dma_rd = '0;
            sb.push_back(e);
        end
        @(negedge clk);
        rst_rr = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rr_cpu.ack === 1'b1 || rr_dma.ack === 1'b1) n++;
        end
        rr_cpu.req = 1'b0; rr_dma.req = 1'b0;
        chk("alt_ack_count", 32'(n), 4);
        chk("alt_last_ack_cycle", 32'(cyc), 11);
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        // CPU priority instance: CPU wins every tie; DMA only after the CPU lets go.
        fp_cpu.req = 1'b1; fp_cpu.cmd = MWRITE; fp_cpu.addr = 9'h030; fp_cpu.wdata = 16'h1111;
        fp_dma.req = 1'b1; fp_dma.cmd = MWRITE; fp_dma.addr = 9'h031; fp_dma.wdata = 16'h2222;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (fp_cpu.ack === 1'b1 || fp_dma.ack === 1'b1) begin
                n++;
                if (n < 4) begin
                    chk($sformatf("fp_prio_win%0d_dma_ack", n), 32'(fp_dma.ack), 0);
                    chk($sformatf("fp_prio_win%0d_cpu_ack", n), 32'(fp_cpu.ack), 1);
                end else begin
                    chk("fp_after_drop_dma_ack", 32'(fp_dma.ack), 1);
                end
                if (n == 3) fp_cpu.req = 1'b0;
            end
        end
        fp_cpu.req = 1'b0; fp_dma.req = 1'b0;
        chk("fp_ack_count", 32'(n), 4);
        @(negedge clk);

        fp_cpu.req = 1'b1; fp_cpu.cmd = MREAD; fp_cpu.addr = 9'h031;
        cyc = 1;
        while (fp_cpu.ack !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        fp_cpu.req = 1'b0;
        chk("fp_rd_latency", 32'(cyc), 32'(2 + FP_LAT));
        chk("fp_rd_cpu_rdata", 32'(fp_cpu.rdata), 32'h2222);
        chk("fp_rd_dma_rdata", 32'(fp_dma.rdata), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
